// File: rtl/back_ground_generator.sv
// Mode-switchable VGA background: solid, colour matrix, scrolling stripes, gradient.
// Registered RGB332 pixel plus border flag; mode commits only at frame start.
module back_ground_generator #(
  parameter int         FRAME_W       = 640,
  parameter int         FRAME_H       = 480,
  parameter int         BORDER_W      = 2,
  parameter logic [7:0] BORDER_COLOR  = 8'hFC,
  parameter logic [7:0] FILL_COLOR    = 8'h58,
  parameter int         MATRIX_LEFT_X = 100,
  parameter int         MATRIX_TOP_Y  = 100,
  parameter int         CELL_LOG2     = 3,
  parameter int         STRIPE_LOG2   = 4,
  parameter int         SCROLL_STEP   = 1
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        startOfFrame,
  input  logic [1:0]  modeReq,
  input  logic        modeLoad,
  output logic [7:0]  BG_RGB,
  output logic        boardersDrawReq,
  output logic [1:0]  activeMode
);

  typedef enum logic [1:0] {
    M_SOLID    = 2'd0,
    M_MATRIX   = 2'd1,
    M_STRIPES  = 2'd2,
    M_GRADIENT = 2'd3
  } mode_e;

  localparam int MTX_SPAN = 16 << CELL_LOG2;

  mode_e       mode_q, mode_d;
  logic [1:0]  pend_mode_q, pend_mode_d;
  logic        pend_valid_q, pend_valid_d;
  logic [9:0]  scroll_q, scroll_d;
  logic [7:0]  rgb_q, rgb_d;
  logic        brd_q, brd_d;

  logic signed [11:0]     dx, dy;
  logic                   in_mtx;
  logic [STRIPE_LOG2:0]   stripe_sum;
  logic [7:0]             grad_sum;
  logic                   out_frame, in_border;
  logic                   commit;

  // state registers, all cleared by the asynchronous reset
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      mode_q       <= M_SOLID;
      pend_mode_q  <= 2'd0;
      pend_valid_q <= 1'b0;
      scroll_q     <= 10'd0;
      rgb_q        <= 8'd0;
      brd_q        <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      pend_mode_q  <= pend_mode_d;
      pend_valid_q <= pend_valid_d;
      scroll_q     <= scroll_d;
      rgb_q        <= rgb_d;
      brd_q        <= brd_d;
    end
  end

  // mode handshake and per-frame scroll update
  always_comb begin
    mode_d       = mode_q;
    pend_mode_d  = pend_mode_q;
    pend_valid_d = pend_valid_q;
    scroll_d     = scroll_q;
    commit       = modeLoad | pend_valid_q;
    if (modeLoad) begin
      pend_mode_d  = modeReq;
      pend_valid_d = 1'b1;
    end
    if (startOfFrame) begin
      if (commit) begin
        mode_d       = mode_e'(modeLoad ? modeReq : pend_mode_q);
        pend_valid_d = 1'b0;
        scroll_d     = 10'd0;
      end else begin
        scroll_d = scroll_q + 10'(SCROLL_STEP);
      end
    end
  end

  // pixel classification using the pre-commit mode and scroll
  always_comb begin
    dx = $signed({1'b0, pixelX}) - $signed(12'(MATRIX_LEFT_X));
    dy = $signed({1'b0, pixelY}) - $signed(12'(MATRIX_TOP_Y));
    in_mtx = (dx >= 0) && (dx < $signed(12'(MTX_SPAN)))
          && (dy >= 0) && (dy < $signed(12'(MTX_SPAN)));
    stripe_sum = pixelX[STRIPE_LOG2:0] + scroll_q[STRIPE_LOG2:0];
    grad_sum   = pixelY[7:0] + scroll_q[7:0];
    out_frame  = (pixelX >= 11'(FRAME_W)) || (pixelY >= 11'(FRAME_H));
    in_border  = (pixelX < 11'(BORDER_W))
              || (pixelX >= 11'(FRAME_W - BORDER_W))
              || (pixelY < 11'(BORDER_W))
              || (pixelY >= 11'(FRAME_H - BORDER_W));
    rgb_d = FILL_COLOR;
    brd_d = 1'b0;
    if (out_frame) begin
      rgb_d = 8'h00;
    end else if (in_border) begin
      rgb_d = BORDER_COLOR;
      brd_d = 1'b1;
    end else begin
      unique case (mode_q)
        M_SOLID:    rgb_d = FILL_COLOR;
        M_MATRIX:   rgb_d = in_mtx ? {dy[CELL_LOG2 +: 4], dx[CELL_LOG2 +: 4]}
                                   : FILL_COLOR;
        M_STRIPES:  rgb_d = stripe_sum[STRIPE_LOG2] ? ~FILL_COLOR : FILL_COLOR;
        M_GRADIENT: rgb_d = grad_sum;
        default:    rgb_d = FILL_COLOR;
      endcase
    end
  end

  assign BG_RGB          = rgb_q;
  assign boardersDrawReq = brd_q;
  assign activeMode      = mode_q;

endmodule
